// File: rtl/img_decr.sv
// img_decr: streaming one-pixel-per-cycle image decryptor (pass, subtract, invert, LFSR-XOR).
// Optional per-frame XOR checksum output enabled by defining IMGDECR_CKSUM_EN.
module img_decr #(
  parameter int FRAME_LEN = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] ibyte,
  input  logic       ivalid,
  output logic       iready,
  input  logic [7:0] value,
  input  logic [0:1] select,
  output logic [0:7] obyte,
  output logic       ovalid,
  input  logic       oready,
`ifdef IMGDECR_CKSUM_EN
  output logic [7:0] cksum,
`endif
  output logic       frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  typedef enum logic [1:0] {M_PASS, M_SUB, M_INV, M_XOR} mode_t;

  state_t         state, state_nxt;
  mode_t          mode_r, mode_eff;
  logic [CW-1:0]  count;
  logic [7:0]     key_r, lfsr, key_eff, k_eff, pix, dec;
  logic           in_xfer, out_xfer, last_px;

  function automatic logic [7:0] lfsr_step(input logic [7:0] k);
    return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
  endfunction

  assign iready   = (!ovalid || oready) && (state != FLUSH);
  assign in_xfer  = ivalid && iready;
  assign out_xfer = ovalid && oready;
  assign pix      = ibyte;

  // The first pixel of a frame must see the freshly sampled key, mode and seed.
  assign key_eff  = (state == IDLE) ? value : key_r;
  assign mode_eff = (state == IDLE) ? mode_t'(select) : mode_r;
  assign k_eff    = (state == IDLE) ? ((value == 8'h00) ? 8'h01 : value) : lfsr;
  assign last_px  = (state == IDLE) ? (FRAME_LEN == 1) : (count == CW'(FRAME_LEN - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    dec = pix;
    unique case (mode_eff)
      M_PASS: dec = pix;
      M_SUB:  dec = pix - key_eff;
      M_INV:  dec = ~pix;
      M_XOR:  dec = pix ^ k_eff;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_xfer) state_nxt = last_px ? FLUSH : STREAM;
      STREAM:  if (in_xfer && last_px) state_nxt = FLUSH;
      FLUSH:   if (out_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      lfsr       <= 8'h01;
      key_r      <= 8'h00;
      mode_r     <= M_PASS;
      obyte      <= 8'h00;
      ovalid     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == FLUSH) && out_xfer;

      if (in_xfer) begin
        lfsr   <= lfsr_step(k_eff);
        obyte  <= dec;
        ovalid <= 1'b1;
        if (state == IDLE) begin
          key_r  <= value;
          mode_r <= mode_t'(select);
          count  <= CW'(1);
        end else begin
          count  <= count + CW'(1);
        end
      end else if (oready) begin
        ovalid <= 1'b0;
      end

      if (state == FLUSH && out_xfer) count <= '0;
    end
  end

`ifdef IMGDECR_CKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cksum <= 8'h00;
    else if (in_xfer && state == IDLE)  cksum <= 8'h00;
    else if (out_xfer)                  cksum <= cksum ^ obyte;
  end
`endif

endmodule
